// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Sits between the program counter and decode. Each cycle it decides whether
// a new fetch may be issued, drives the synchronous instruction ROM (one cycle
// read latency), captures the returned word together with the address it was
// read from, and hands instructions to decode over a valid/ready handshake.
// The PC is told to advance only in cycles where a fetch is actually issued.
//
// Parameters:
//   ADDR_W    - PC / ROM address width
//   DATA_W    - instruction width
//   BUF_DEPTH - instruction buffer entries (power of two, >= 2)
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   pc_in        current PC value
//   pc_inc       PC increment enable, high exactly in issue cycles
//   rom_addr     ROM read address (always pc_in)
//   rom_rd_en    ROM read strobe (high in issue cycles)
//   rom_data     ROM read data, valid the cycle after rom_rd_en
//   flush        redirect: drop buffered and in-flight instructions
//   instr_valid  buffer head holds an instruction for decode
//   instr_ready  decode accepts the head this cycle
//   instr_data   head instruction word
//   instr_pc     address the head instruction was fetched from
//
// Optional build macro IFETCH_PERF_CNT_EN adds:
//   fetch_cnt    saturating count of buffer pushes
//   stall_cnt    saturating count of cycles with instr_valid && !instr_ready
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd_en,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              flush,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] pcBuf_q    [BUF_DEPTH];
    logic [DATA_W-1:0] instrBuf_q [BUF_DEPTH];

    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflightPc_q, inflightPc_d;

    logic              pop;
    logic              push;
    logic              issue;
    logic [OCC_W-1:0]  occupancy;

    // Handshake and issue decisions. Occupancy counts everything already
    // committed to the buffer (held plus in flight) minus what decode takes
    // this cycle, so a slot freed by a pop can be refilled in the same cycle
    // and the fetch sustains one instruction per cycle.
    assign instr_valid = (count_q != '0) && !flush;
    assign pop         = instr_valid && instr_ready;
    assign push        = inflight_q && !flush;
    assign occupancy   = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign issue       = reset_n && !flush && (occupancy < OCC_W'(BUF_DEPTH));

    assign pc_inc      = issue;
    assign rom_rd_en   = issue;
    assign rom_addr    = pc_in;

    assign instr_data  = instrBuf_q[rdPtr_q];
    assign instr_pc    = pcBuf_q[rdPtr_q];

    // Next-state for pointers, occupancy and the in-flight tracker. A flush
    // empties everything and forgets the outstanding read, so a word returning
    // in the flush cycle is never written. Pointers wrap naturally because the
    // depth is a power of two.
    always_comb begin
        rdPtr_d      = rdPtr_q;
        wrPtr_d      = wrPtr_q;
        count_d      = count_q;
        inflight_d   = issue;
        inflightPc_d = inflightPc_q;
        if (flush) begin
            rdPtr_d    = '0;
            wrPtr_d    = '0;
            count_d    = '0;
            inflight_d = 1'b0;
        end else begin
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            if (push) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (issue) begin
                inflightPc_d = pc_in;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdPtr_q      <= '0;
            wrPtr_q      <= '0;
            count_q      <= '0;
            inflight_q   <= 1'b0;
            inflightPc_q <= '0;
        end else begin
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
        end
    end

    // Instruction buffer storage. Entries are cleared by reset so the head
    // outputs read zero while reset is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pcBuf_q[i]    <= '0;
                instrBuf_q[i] <= '0;
            end
        end else if (push) begin
            pcBuf_q[wrPtr_q]    <= inflightPc_q;
            instrBuf_q[wrPtr_q] <= rom_data;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetchCnt_q;
    logic [15:0] stallCnt_q;

    // Saturating performance counters; only reset clears them, a flush does not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetchCnt_q <= '0;
            stallCnt_q <= '0;
        end else begin
            if (push && (fetchCnt_q != 16'hFFFF)) begin
                fetchCnt_q <= fetchCnt_q + 16'd1;
            end
            if (instr_valid && !instr_ready && (stallCnt_q != 16'hFFFF)) begin
                stallCnt_q <= stallCnt_q + 16'd1;
            end
        end
    end

    assign fetch_cnt = fetchCnt_q;
    assign stall_cnt = stallCnt_q;
`else
    // Counters not built: no extra ports and no extra state.
`endif

endmodule
